// File: rtl/run_stream_gen_if.sv
// Descriptor handshake bundle for run_stream_gen: (bit, length) descriptors
// with valid/ready flow control.
interface run_stream_gen_if #(
  parameter int LEN_W = 4
);
  logic             run_valid;
  logic             run_ready;
  logic             run_bit;
  logic [LEN_W-1:0] run_len;

  modport master (
    output run_valid,
    output run_bit,
    output run_len,
    input  run_ready
  );

  modport slave (
    input  run_valid,
    input  run_bit,
    input  run_len,
    output run_ready
  );
endinterface

// File: rtl/run_stream_gen.sv
// Serial run-length stream transmitter: expands (bit, length) descriptors into
// one bit per clock. Optional STREAM_STATS_EN adds saturating run/bit counters.
//
// state | meaning
// IDLE  | no run on x, x=IDLE_LEVEL, pending slot empty
// SEND  | a run bit is on x; r_remaining bits of it still follow
module run_stream_gen #(
  parameter int   LEN_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  run_stream_gen_if.slave      s_run,
  output logic                 x,
  output logic                 x_valid,
  output logic                 run_done,
  output logic                 busy
`ifdef STREAM_STATS_EN
  ,
  output logic [15:0]          runs_sent,
  output logic [15:0]          bits_sent
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_x;
  logic             r_x_valid;
  logic             r_run_done;
  logic [LEN_W-1:0] r_remaining;
  logic             r_pend_full;
  logic             r_pend_bit;
  logic [LEN_W-1:0] r_pend_len;

  state_t           w_state_nxt;
  logic             w_x_nxt;
  logic             w_x_valid_nxt;
  logic             w_run_done_nxt;
  logic [LEN_W-1:0] w_remaining_nxt;
  logic             w_pend_full_nxt;
  logic             w_pend_bit_nxt;
  logic [LEN_W-1:0] w_pend_len_nxt;

  logic             w_accept;
  logic             w_len_nz;

  assign s_run.run_ready = !r_pend_full;
  assign w_accept        = s_run.run_valid && !r_pend_full;
  assign w_len_nz        = (s_run.run_len != '0);

  assign x        = r_x;
  assign x_valid  = r_x_valid;
  assign run_done = r_run_done;
  assign busy     = (r_state == SEND) || r_pend_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_x         <= IDLE_LEVEL;
      r_x_valid   <= 1'b0;
      r_run_done  <= 1'b0;
      r_remaining <= '0;
      r_pend_full <= 1'b0;
      r_pend_bit  <= 1'b0;
      r_pend_len  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_x_valid   <= w_x_valid_nxt;
      r_run_done  <= w_run_done_nxt;
      r_remaining <= w_remaining_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_pend_bit  <= w_pend_bit_nxt;
      r_pend_len  <= w_pend_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_x_valid_nxt   = r_x_valid;
    w_run_done_nxt  = 1'b0;
    w_remaining_nxt = r_remaining;
    w_pend_full_nxt = r_pend_full;
    w_pend_bit_nxt  = r_pend_bit;
    w_pend_len_nxt  = r_pend_len;

    unique case (r_state)
      IDLE: begin
        if (w_accept && w_len_nz) begin
          w_state_nxt     = SEND;
          w_x_nxt         = s_run.run_bit;
          w_x_valid_nxt   = 1'b1;
          w_remaining_nxt = s_run.run_len - LEN_W'(1);
          w_run_done_nxt  = (s_run.run_len == LEN_W'(1));
        end
      end

      SEND: begin
        if (r_remaining != '0) begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          w_run_done_nxt  = (r_remaining == LEN_W'(1));
          // zero-length descriptors are swallowed and never occupy the slot
          if (w_accept && w_len_nz) begin
            w_pend_full_nxt = 1'b1;
            w_pend_bit_nxt  = s_run.run_bit;
            w_pend_len_nxt  = s_run.run_len;
          end
        end else if (r_pend_full) begin
          w_x_nxt         = r_pend_bit;
          w_remaining_nxt = r_pend_len - LEN_W'(1);
          w_run_done_nxt  = (r_pend_len == LEN_W'(1));
          w_pend_full_nxt = 1'b0;
        end else if (w_accept && w_len_nz) begin
          w_x_nxt         = s_run.run_bit;
          w_remaining_nxt = s_run.run_len - LEN_W'(1);
          w_run_done_nxt  = (s_run.run_len == LEN_W'(1));
        end else begin
          w_state_nxt   = IDLE;
          w_x_nxt       = IDLE_LEVEL;
          w_x_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_x_nxt       = IDLE_LEVEL;
        w_x_valid_nxt = 1'b0;
      end
    endcase
  end

`ifdef STREAM_STATS_EN
  logic [15:0] r_runs_sent;
  logic [15:0] r_bits_sent;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_runs_sent <= '0;
      r_bits_sent <= '0;
    end else begin
      if (r_run_done && (r_runs_sent != 16'hFFFF))
        r_runs_sent <= r_runs_sent + 16'd1;
      if (r_x_valid && (r_bits_sent != 16'hFFFF))
        r_bits_sent <= r_bits_sent + 16'd1;
    end
  end

  assign runs_sent = r_runs_sent;
  assign bits_sent = r_bits_sent;
`endif

endmodule

// File: tb/tb_run_stream_gen.sv
// Directed bench for run_stream_gen: idle, back-to-back runs, single-bit run,
// zero-length descriptor, mid-run reset and (with STREAM_STATS_EN) counters.
module tb_run_stream_gen;

  logic clk;
  logic reset;
  logic x;
  logic x_valid;
  logic run_done;
  logic busy;
`ifdef STREAM_STATS_EN
  logic [15:0] runs_sent;
  logic [15:0] bits_sent;
`endif

  int checks   = 0;
  int failures = 0;

  logic       d_bit[8];
  logic [3:0] d_len[8];
  int         n_d;

  run_stream_gen_if #(.LEN_W(4)) rif ();

  run_stream_gen #(.LEN_W(4), .IDLE_LEVEL(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_run    (rif),
    .x        (x),
    .x_valid  (x_valid),
    .run_done (run_done),
    .busy     (busy)
`ifdef STREAM_STATS_EN
    ,
    .runs_sent(runs_sent),
    .bits_sent(bits_sent)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " x"},       32'(x),             32'd0);
    chk({tag, " x_valid"}, 32'(x_valid),       32'd0);
    chk({tag, " run_done"},32'(run_done),      32'd0);
    chk({tag, " busy"},    32'(busy),          32'd0);
    chk({tag, " ready"},   32'(rif.run_ready), 32'd1);
  endtask

  // Offers d_*[0..n_d-1] back-to-back; after edge k checks bit (ncyc-k) of each mask.
  task automatic play(input string tag, input int ncyc,
                      input logic [31:0] ex, input logic [31:0] ev,
                      input logic [31:0] erd, input logic [31:0] er);
    int   idx;
    logic acc;
    idx = 0;
    rif.run_valid = 1'b1;
    rif.run_bit   = d_bit[0];
    rif.run_len   = d_len[0];
    for (int k = 1; k <= ncyc; k++) begin
      acc = rif.run_valid && rif.run_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < n_d) begin
          rif.run_bit = d_bit[idx];
          rif.run_len = d_len[idx];
        end else begin
          rif.run_valid = 1'b0;
        end
      end
      chk($sformatf("%s x c%0d", tag, k),        32'(x),             32'(ex[ncyc-k]));
      chk($sformatf("%s x_valid c%0d", tag, k),  32'(x_valid),       32'(ev[ncyc-k]));
      chk($sformatf("%s run_done c%0d", tag, k), 32'(run_done),      32'(erd[ncyc-k]));
      chk($sformatf("%s ready c%0d", tag, k),    32'(rif.run_ready), 32'(er[ncyc-k]));
      chk($sformatf("%s busy c%0d", tag, k),     32'(busy),          32'(ev[ncyc-k]));
    end
    chk($sformatf("%s all accepted", tag), 32'(idx), 32'(n_d));
    rif.run_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    rif.run_valid = 1'b0;
    rif.run_bit   = 1'b0;
    rif.run_len   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_idle($sformatf("idle c%0d", i));
    end

    // Six back-to-back runs: 000 1111 000 111 00 1
    d_bit[0] = 1'b0; d_len[0] = 4'd3;
    d_bit[1] = 1'b1; d_len[1] = 4'd4;
    d_bit[2] = 1'b0; d_len[2] = 4'd3;
    d_bit[3] = 1'b1; d_len[3] = 4'd3;
    d_bit[4] = 1'b0; d_len[4] = 4'd2;
    d_bit[5] = 1'b1; d_len[5] = 4'd1;
    n_d = 6;
    play("stream", 17,
         32'({16'b0001111000111001, 1'b0}),
         32'({16'hFFFF, 1'b0}),
         32'({16'h224B, 1'b0}),
         32'(17'b10010001001001011));
`ifdef STREAM_STATS_EN
    chk("stats runs_sent", 32'(runs_sent), 32'd6);
    chk("stats bits_sent", 32'(bits_sent), 32'd16);
`endif

    d_bit[0] = 1'b1; d_len[0] = 4'd1;
    n_d = 1;
    play("single", 2, 32'b10, 32'b10, 32'b10, 32'b11);

    // (1,5), zero-length descriptor, (0,2)
    d_bit[0] = 1'b1; d_len[0] = 4'd5;
    d_bit[1] = 1'b0; d_len[1] = 4'd0;
    d_bit[2] = 1'b0; d_len[2] = 4'd2;
    n_d = 3;
    play("zlen", 8, 32'b11111000, 32'b11111110, 32'b00001010, 32'b11000111);

    // Reset two cycles into (1,8) with (0,4) pending
    d_bit[0] = 1'b1; d_len[0] = 4'd8;
    d_bit[1] = 1'b0; d_len[1] = 4'd4;
    n_d = 2;
    play("abort", 2, 32'b11, 32'b11, 32'b00, 32'b10);
    reset = 1'b0;
    #1;
    chk_idle("abort async");
    repeat (2) @(posedge clk);
    #1;
    chk_idle("abort held");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk_idle($sformatf("post-abort c%0d", i));
    end

`ifdef STREAM_STATS_EN
    rif.run_bit   = 1'b1;
    rif.run_len   = 4'd1;
    rif.run_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    rif.run_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat runs_sent", 32'(runs_sent), 32'h0000FFFF);
    chk("sat bits_sent", 32'(bits_sent), 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
